// File: rtl/cabac_rate_pkg.sv
// cabac_rate_pkg: shared types and constants for the CABAC base-level tracker.
package cabac_rate_pkg;
  localparam int DEF_LEVEL_W = 16;
  localparam int DEF_IDX_W = 8;
  localparam int DEF_C1_MAX = 8;
  localparam int DEF_C2_MAX = 1;
  localparam int DEF_CG_SIZE = 16;
  localparam logic [1:0] BASE_ZERO = 2'd0;
  localparam logic [1:0] BASE_MIN = 2'd1;
  localparam logic [1:0] BASE_G1 = 2'd2;
  localparam logic [1:0] BASE_G2 = 2'd3;
  typedef enum logic {IDLE, ACTIVE} state_t;
  typedef struct packed {
    logic [1:0] base;
    logic [DEF_LEVEL_W-1:0] remaining;
    logic esc;
    logic [DEF_IDX_W-1:0] c1;
    logic [DEF_IDX_W-1:0] c2;
    logic [1:0] ctx;
    logic last;
  } result_t;
endpackage

// File: rtl/base_level_lut.sv
// base_level_lut: per-coefficient baseLevel, remainder and next context counters.
module base_level_lut
  import cabac_rate_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int C1_MAX = DEF_C1_MAX,
  parameter int C2_MAX = DEF_C2_MAX
) (
  input  logic [LEVEL_W-1:0] abs_level,
  input  logic [IDX_W-1:0]   c1,
  input  logic [IDX_W-1:0]   c2,
  input  logic [1:0]         ctx,
  output logic [1:0]         base,
  output logic [LEVEL_W-1:0] remaining,
  output logic               esc,
  output logic [IDX_W-1:0]   c1_next,
  output logic [IDX_W-1:0]   c2_next,
  output logic [1:0]         ctx_next
);
  logic nz, gt1, c1_ok, c2_ok;
  logic [LEVEL_W-1:0] base_ext;
  always_comb begin
    nz = abs_level != '0;
    gt1 = abs_level > LEVEL_W'(1);
    c1_ok = c1 < IDX_W'(C1_MAX);
    c2_ok = c2 < IDX_W'(C2_MAX);
    base = !nz ? BASE_ZERO : !c1_ok ? BASE_MIN : c2_ok ? BASE_G2 : BASE_G1;
    base_ext = LEVEL_W'(base);
    remaining = abs_level >= base_ext ? abs_level - base_ext : '0;
    esc = nz && abs_level >= base_ext;
    c1_next = nz && c1_ok ? c1 + 1'b1 : c1;
    c2_next = nz && gt1 && c1_ok && c2_ok ? c2 + 1'b1 : c2;
    // a zero greater1 context is absorbing for the rest of the group
    ctx_next = !nz ? ctx : gt1 ? 2'd0 : ctx == 2'd0 ? 2'd0 : ctx == 2'd3 ? 2'd3 : ctx + 2'd1;
  end
endmodule

// File: rtl/cg_base_level_tracker.sv
// cg_base_level_tracker: streams one 4x4 group's levels, tracking c1/c2/greater1 context.
module cg_base_level_tracker
  import cabac_rate_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int C1_MAX = DEF_C1_MAX,
  parameter int C2_MAX = DEF_C2_MAX,
  parameter int CG_SIZE = DEF_CG_SIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LEVEL_W-1:0] in_abs_level,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_base_level,
  output logic [LEVEL_W-1:0] out_remaining,
  output logic               out_esc,
  output logic [IDX_W-1:0]   out_c1_idx,
  output logic [IDX_W-1:0]   out_c2_idx,
  output logic [1:0]         out_gt1_ctx,
  output logic               out_last,
  output logic               busy,
  output logic               err_len
);
  localparam int CNT_W = $clog2(CG_SIZE + 1);
  state_t state;
  result_t r;
  logic [IDX_W-1:0] c1, c2, c1_n, c2_n;
  logic [1:0] ctx, ctx_n, base;
  logic [LEVEL_W-1:0] rem;
  logic esc, accept, at_end, last;
  logic [CNT_W-1:0] cnt;
  assign in_ready = state == ACTIVE && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign at_end = cnt == CNT_W'(CG_SIZE - 1);
  assign last = in_last || at_end;
  assign busy = state == ACTIVE;
  assign out_base_level = r.base;
  assign out_remaining = r.remaining;
  assign out_esc = r.esc;
  assign out_c1_idx = r.c1;
  assign out_c2_idx = r.c2;
  assign out_gt1_ctx = r.ctx;
  assign out_last = r.last;
  base_level_lut #(
    .LEVEL_W(LEVEL_W),
    .IDX_W(IDX_W),
    .C1_MAX(C1_MAX),
    .C2_MAX(C2_MAX)
  ) u_lut (
    .abs_level(in_abs_level),
    .c1(c1),
    .c2(c2),
    .ctx(ctx),
    .base(base),
    .remaining(rem),
    .esc(esc),
    .c1_next(c1_n),
    .c2_next(c2_n),
    .ctx_next(ctx_n)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      r <= '0;
      c1 <= '0;
      c2 <= '0;
      ctx <= 2'd1;
      cnt <= '0;
      err_len <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        state <= ACTIVE;
        c1 <= '0;
        c2 <= '0;
        ctx <= 2'd1;
        cnt <= '0;
        err_len <= 1'b0;
      end
      if (accept) begin
        r <= '{base: base, remaining: rem, esc: esc, c1: c1, c2: c2, ctx: ctx, last: last};
        out_valid <= 1'b1;
        c1 <= c1_n;
        c2 <= c2_n;
        ctx <= ctx_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= IDLE;
          if (!in_last) err_len <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/cg_base_level_tracker.md
Name: cg_base_level_tracker

Overview:
Per-coefficient-group successor to the single-shot base-level calculator in the CABAC rate estimator. It consumes a stream of absolute coefficient levels for one 4x4 coefficient group in reverse scan order. It maintains the c1Idx, c2Idx and greater1 context counters internally, and emits one result per coefficient: baseLevel, abs_level_remaining and an escape flag. Its output feeds the RDOQ bit-cost accumulator through a registered valid/ready stage.

Parameters:
LEVEL_W, 16, width of absolute coefficient level and remaining value
IDX_W, 8, width of c1/c2 index counters
C1_MAX, 8, number of greater1 flags coded per group before baseLevel drops to 1
C2_MAX, 1, number of greater2 flags coded per group
CG_SIZE, 16, maximum coefficients per group

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin new group; clears counters (honoured only in IDLE)
in_valid  in  1  coefficient present
in_ready  out  1  coefficient accepted when in_valid && in_ready
in_abs_level  in  LEVEL_W  absolute coefficient level
in_last  in  1  final coefficient of group
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_base_level  out  2  0 (zero coeff), 1, 2 or 3
out_remaining  out  LEVEL_W  abs - base when abs >= base, else 0
out_esc  out  1  (abs >= base) && base != 0
out_c1_idx  out  IDX_W  c1Idx used for this coefficient (pre-update)
out_c2_idx  out  IDX_W  c2Idx used for this coefficient (pre-update)
out_gt1_ctx  out  2  greater1 context used (pre-update)
out_last  out  1  result closes the group
busy  out  1  FSM in ACTIVE
err_len  out  1  sticky: group hit CG_SIZE without in_last

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: every output is 0; FSM goes to IDLE; internal c1/c2 = 0 and gt1_ctx = 1.
- FSM states:
  - IDLE: in_ready = 0. start -> ACTIVE; c1 = 0, c2 = 0, gt1_ctx = 1, beat count = 0, err_len cleared.
  - ACTIVE: in_ready = !out_valid || out_ready. When the last beat is accepted -> IDLE.
  - start in ACTIVE is ignored. start in the same cycle as the last-beat accept is also ignored; the next group must assert start after busy falls.
- Per accepted beat, with c1, c2 and ctx taken before update:
  - abs == 0: base = 0; counters unchanged.
  - abs != 0 and c1 >= C1_MAX: base = 1.
  - abs != 0, c1 < C1_MAX, c2 < C2_MAX: base = 3.
  - abs != 0, c1 < C1_MAX, c2 >= C2_MAX: base = 2.
- Counter updates on a nonzero beat:
  - c1 increments, saturating at C1_MAX.
  - If abs > 1 and pre-update c1 < C1_MAX, c2 increments, saturating at C2_MAX.
  - gt1_ctx: if abs > 1 it becomes 0; else if ctx != 0 it becomes min(ctx + 1, 3). Once 0, it stays 0 for the rest of the group.
- Output stage:
  - Latency is 1 cycle from accept to out_valid.
  - The output register holds while out_valid && !out_ready.
  - Full throughput: one beat per cycle when out_ready = 1.
- Last-beat rules:
  - out_last = in_last, or the accepted beat is number CG_SIZE.
  - If the CG_SIZE-th beat arrives without in_last, err_len is set and the FSM returns to IDLE.
  - Any in_valid while in IDLE is not accepted.
- Arithmetic: base is zero-extended for the subtraction. out_remaining never underflows; it is forced to 0 when abs < base.
- A reset mid-group discards the group and any pending output immediately.

Decomposition:
- Package cabac_rate_pkg holds:
  - the FSM state enum (IDLE, ACTIVE);
  - the base-level constants BASE_ZERO = 0, BASE_MIN = 1, BASE_G1 = 2, BASE_G2 = 3;
  - default C1_MAX and C2_MAX;
  - a packed result struct {base, remaining, esc, c1, c2, ctx, last}.
- One natural sub-module: base_level_lut. It is combinational: from abs, c1, c2 and ctx it produces base, remaining, esc and the next c1, c2 and ctx.

Test Plan:
1. rst held 2 cycles with in_valid = 1 -> all outputs 0, in_ready = 0, busy = 0.
2. start, then abs = [3,1,2,0,5] with last on 5, out_ready = 1:
   - base = [3,2,2,0,2]
   - remaining = [0,0,0,0,3]
   - esc = [1,0,1,0,1]
   - c1 = [0,1,2,3,3]; c2 = [0,1,1,1,1]
   - ctx = [1,0,0,0,0]
   - out_last only on beat 5.
3. start, then ten beats of abs = 1, last on beat 10:
   - base = 3 for beats 1-8, then 1 for beats 9-10
   - ctx = [1,2,3,3,...]
   - esc = 1 only on beats 9-10
   - c1 saturates at 8.
4. Backpressure: out_ready low for 3 cycles mid-group -> output holds stable, in_ready = 0, no beat lost or duplicated.
5. 16 beats of abs = 2 with no in_last -> out_last on beat 16, err_len = 1, busy falls; next start clears err_len.
6. rst asserted mid-group after 3 beats, then start and abs = [4] -> base = 3, remaining = 1, c1 = 0.
